mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single-ported system memory (21-bit physical address, 8-bit data, separate re/we strobes, one-cycle registered read) between two requesters: the CPU core port and the block-transfer/DMA port.
- Grants at most one access per cycle and guarantees re and we are never asserted together.
- Returns read data with a valid strobe to the owning requester.
- Enforces bounded starvation, and lets DMA lock the bus for bursts.

Parameters:
- CPU_RUN_MAX, 8: maximum consecutive CPU grants while DMA is waiting; the next grant then goes to DMA.
- LOCK_MAX, 32: maximum consecutive DMA grants under dma_lock while CPU is waiting.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU access request; held until cpu_gnt.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  21  CPU physical address.
- cpu_wdata  input  8  CPU write data.
- cpu_gnt  output  1  access issued to memory this cycle.
- cpu_rvalid  output  1  cpu_rdata valid (cycle after a CPU read grant).
- cpu_rdata  output  8  read data.
- dma_req, dma_we, dma_addr[20:0], dma_wdata[7:0], dma_gnt, dma_rvalid, dma_rdata[7:0]: same as the CPU port, for DMA.
- dma_lock  input  1  DMA requests to keep the bus across consecutive grants.
- mem_addr  output  21  to memory addr.
- mem_dIn  output  8  to memory write data.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_dOut  input  8  memory read data, valid the cycle after mem_re.

Behaviour:
- Grant is combinational from the current-cycle requests plus registered state.
- Exactly one of cpu_gnt/dma_gnt is high when any request is high; both are low when no request is high.
- mem_* reflect the granted requester in the same cycle.
  - mem_re = gnt & ~we; mem_we = gnt & we.
  - With no grant: mem_re = mem_we = 0, mem_addr = 0, mem_dIn = 0.
- Arbitration states (registered): IDLE, CPU_OWN, DMA_OWN, DMA_LOCKED.
- Grant decision, applied in priority order:
  - DMA_LOCKED with dma_req: grant DMA, unless lock_cnt == LOCK_MAX and cpu_req, which grants CPU and moves to CPU_OWN.
  - cpu_run_cnt == CPU_RUN_MAX with dma_req: grant DMA.
  - cpu_req: grant CPU (default CPU priority).
  - Otherwise dma_req: grant DMA.
- Next state:
  - CPU grant -> CPU_OWN.
  - DMA grant with dma_lock -> DMA_LOCKED.
  - DMA grant without dma_lock -> DMA_OWN.
  - No grant -> IDLE.
- cpu_run_cnt:
  - Increments on each CPU grant while dma_req is high, saturating at CPU_RUN_MAX.
  - Clears on any DMA grant, and on any cycle with dma_req low.
- lock_cnt:
  - Increments on each DMA grant in DMA_LOCKED while cpu_req is high, saturating at LOCK_MAX.
  - Clears on leaving DMA_LOCKED.
- Deasserting dma_lock takes effect at the next grant decision: DMA_LOCKED is left and normal priority applies.
- Read return:
  - Registered rd_owner (2 bits: none/CPU/DMA) is set on a read grant.
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_dOut; the other port's rdata is held at 0.
  - Writes produce no rvalid.
- Back-to-back reads, including alternating owners, are supported every cycle with no bubble.
- Latency: grant in the request cycle if the requester wins; read data one cycle after grant.
- A requester with req high and gnt low must hold addr/we/wdata stable. The arbiter does not latch them.
- Reset (asynchronous, any time):
  - State -> IDLE; cpu_run_cnt = lock_cnt = 0; rd_owner = none.
  - cpu_rvalid = dma_rvalid = 0; rdata = 0.
  - A read granted in the cycle of reset assertion never produces rvalid.
  - Grant outputs follow the decision rules with reset state, so requests held through reset release are granted CPU-first.
- mem_re and mem_we are never simultaneously 1. The bench asserts this every cycle.

Test Plan:
- CPU read alone: cpu_req=1, we=0, addr=21'h000123 -> cpu_gnt=1, mem_re=1, mem_addr=21'h000123 same cycle; next cycle cpu_rvalid=1, cpu_rdata=mem_dOut, dma_rvalid=0.
- Contention, no lock: cpu_req and dma_req held high 20 cycles -> grants CPU×8, DMA×1, CPU×8, DMA×1, CPU×2; no cycle with both grants.
- DMA locked burst: dma_req=dma_lock=1 and cpu_req=1 -> once DMA holds the bus, 32 consecutive dma_gnt, then cpu_gnt; with cpu_req=0 the lock persists indefinitely.
- Alternating reads: CPU read 21'h1F0004 then DMA read 21'h000010 on consecutive cycles -> cpu_rvalid then dma_rvalid on consecutive cycles, each carrying its own mem_dOut; no bubble.
- Writes: DMA write addr 21'h1F0100, data 8'hA5 -> mem_we=1, mem_re=0, mem_dIn=8'hA5; no rvalid on either port.
- Reset mid-read: assert rst asynchronously in the cycle after a CPU read grant -> cpu_rvalid drops immediately; after release, held requests are granted CPU first; all counters are 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter (CPU, DMA) in front of a single-ported memory with a one-cycle registered read.
// Grant is combinational in the request cycle. Read data returns one cycle later. A requester that loses must hold its request.
module mem_bus_arbiter #(
    parameter int CPU_RUN_MAX = 8,
    parameter int LOCK_MAX    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [20:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_dIn,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_dOut
);
    localparam int RW = $clog2(CPU_RUN_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN, DMA_LOCKED} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DMA} owner_t;

    state_t        state;
    owner_t        rd_owner;
    logic [RW-1:0] run_cnt;
    logic [LW-1:0] lock_cnt;
    logic          gnt_c, gnt_d, sel_we;

    // Priority: lock (until it expires with CPU waiting), anti-starvation for DMA, then CPU.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (state == DMA_LOCKED && dma_req && dma_lock) begin
            if (lock_cnt == LW'(LOCK_MAX) && cpu_req)
                gnt_c = 1'b1;
            else
                gnt_d = 1'b1;
        end else if (run_cnt == RW'(CPU_RUN_MAX) && dma_req) begin
            gnt_d = 1'b1;
        end else if (cpu_req) begin
            gnt_c = 1'b1;
        end else if (dma_req) begin
            gnt_d = 1'b1;
        end
    end

    assign cpu_gnt  = gnt_c;
    assign dma_gnt  = gnt_d;
    assign sel_we   = gnt_c ? cpu_we : (gnt_d ? dma_we : 1'b0);
    assign mem_re   = (gnt_c | gnt_d) & ~sel_we;
    assign mem_we   = (gnt_c | gnt_d) & sel_we;
    assign mem_addr = gnt_c ? cpu_addr  : (gnt_d ? dma_addr  : '0);
    assign mem_dIn  = gnt_c ? cpu_wdata : (gnt_d ? dma_wdata : '0);

    // Read return is steered by the registered owner, so reset kills it immediately.
    assign cpu_rvalid = (rd_owner == RD_CPU);
    assign dma_rvalid = (rd_owner == RD_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_dOut : '0;
    assign dma_rdata  = dma_rvalid ? mem_dOut : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            run_cnt  <= '0;
            lock_cnt <= '0;
            rd_owner <= RD_NONE;
        end else begin
            if (gnt_c)
                state <= CPU_OWN;
            else if (gnt_d)
                state <= dma_lock ? DMA_LOCKED : DMA_OWN;
            else
                state <= IDLE;

            if (!dma_req || gnt_d)
                run_cnt <= '0;
            else if (gnt_c && run_cnt != RW'(CPU_RUN_MAX))
                run_cnt <= run_cnt + RW'(1);

            // Entering the lock does not count; only grants already inside it with CPU waiting.
            if (!(gnt_d && dma_lock))
                lock_cnt <= '0;
            else if (state == DMA_LOCKED && cpu_req && lock_cnt != LW'(LOCK_MAX))
                lock_cnt <= lock_cnt + LW'(1);

            if (gnt_c && !cpu_we)
                rd_owner <= RD_CPU;
            else if (gnt_d && !dma_we)
                rd_owner <= RD_DMA;
            else
                rd_owner <= RD_NONE;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed table, hand sequences for reset/contention/lock, then random traffic against a reference model.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [20:0] dma_addr;
    logic [7:0]  dma_wdata, dma_rdata;
    logic [20:0] mem_addr;
    logic [7:0]  mem_dIn, mem_dOut;
    logic        mem_re, mem_we;

    mem_bus_arbiter #(.CPU_RUN_MAX(8), .LOCK_MAX(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_dIn(mem_dIn), .mem_re(mem_re), .mem_we(mem_we), .mem_dOut(mem_dOut)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hval(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
    endfunction

    // Memory: registered read of an address-derived byte; garbage when not reading.
    always @(posedge clk) mem_dOut <= mem_re ? hval(mem_addr) : 8'($urandom);

    typedef struct {
        logic cr, cw; logic [20:0] ca; logic [7:0] cd;
        logic dr, dw; logic [20:0] da; logic [7:0] dd; logic dl;
    } stim_t;
    typedef struct { stim_t s; logic [3:0] exp; } vec_t;   // exp = {cpu_gnt,dma_gnt,cpu_rvalid,dma_rvalid}

    int n_chk = 0, n_fail = 0;

    // Reference model: who has been winning, and for how long, in plain counts.
    bit          m_locked;
    int          m_cstreak, m_lstreak;
    int          m_rd_own;
    logic [20:0] m_rd_addr;

    task automatic model_reset();
        m_locked = 0; m_cstreak = 0; m_lstreak = 0; m_rd_own = 0; m_rd_addr = '0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        cpu_req = s.cr; cpu_we = s.cw; cpu_addr = s.ca; cpu_wdata = s.cd;
        dma_req = s.dr; dma_we = s.dw; dma_addr = s.da; dma_wdata = s.dd; dma_lock = s.dl;
    endtask

    function automatic stim_t mk(input logic cr, cw, input logic [20:0] ca, input logic [7:0] cd,
                                 input logic dr, dw, input logic [20:0] da, input logic [7:0] dd, input logic dl);
        stim_t s;
        s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd; s.dr = dr; s.dw = dw; s.da = da; s.dd = dd; s.dl = dl;
        return s;
    endfunction

    // Called at posedge+1: drive, check combinational outputs against the model, advance to next posedge+1.
    task automatic cyc(input stim_t s, output logic [3:0] obs);
        int          w;
        logic        wwe;
        logic [20:0] ea;
        logic [7:0]  ed;
        logic [50:0] act, exp;
        bit          nl;
        drive(s);
        #3;
        if (m_locked && s.dr && s.dl) w = (m_lstreak == 32 && s.cr) ? 1 : 2;
        else if (m_cstreak == 8 && s.dr) w = 2;
        else if (s.cr) w = 1;
        else if (s.dr) w = 2;
        else w = 0;
        wwe = (w == 1) ? s.cw : (w == 2) ? s.dw : 1'b0;
        ea  = (w == 1) ? s.ca : (w == 2) ? s.da : 21'h0;
        ed  = (w == 1) ? s.cd : (w == 2) ? s.dd : 8'h0;
        exp = {w == 1, w == 2, w != 0 && !wwe, w != 0 && wwe, ea, ed,
               m_rd_own == 1, (m_rd_own == 1) ? hval(m_rd_addr) : 8'h0,
               m_rd_own == 2, (m_rd_own == 2) ? hval(m_rd_addr) : 8'h0};
        act = {cpu_gnt, dma_gnt, mem_re, mem_we, mem_addr, mem_dIn, cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata};
        chk("outputs", 64'(act), 64'(exp));
        chk("re_we_excl", 64'(mem_re & mem_we), 64'(0));
        obs = {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid};
        m_rd_own  = (w != 0 && !wwe) ? w : 0;
        m_rd_addr = ea;
        if (!s.dr || w == 2) m_cstreak = 0;
        else if (w == 1 && m_cstreak < 8) m_cstreak++;
        nl = (w == 2) && s.dl;
        if (!nl) m_lstreak = 0;
        else if (m_locked && s.cr && m_lstreak < 32) m_lstreak++;
        m_locked = nl;
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[10];
    stim_t       idle, s;
    logic [3:0]  obs;
    logic        cpend, dpend;

    initial begin
        idle = mk(0, 0, 21'h0, 8'h0, 0, 0, 21'h0, 8'h0, 0);
        tbl[0] = '{mk(1, 0, 21'h000123, 8'h00, 0, 0, 21'h0, 8'h00, 0), 4'b1000};
        tbl[1] = '{idle,                                                4'b0010};
        tbl[2] = '{mk(1, 0, 21'h1F0004, 8'h00, 0, 0, 21'h0, 8'h00, 0), 4'b1000};
        tbl[3] = '{mk(0, 0, 21'h0, 8'h00, 1, 0, 21'h000010, 8'h00, 0), 4'b0110};
        tbl[4] = '{idle,                                                4'b0001};
        tbl[5] = '{mk(0, 0, 21'h0, 8'h00, 1, 1, 21'h1F0100, 8'hA5, 0), 4'b0100};
        tbl[6] = '{idle,                                                4'b0000};
        tbl[7] = '{mk(1, 1, 21'h000200, 8'h3C, 0, 0, 21'h0, 8'h00, 0), 4'b1000};
        tbl[8] = '{mk(1, 0, 21'h0ABCDE, 8'h00, 1, 0, 21'h012345, 8'h00, 0), 4'b1000};
        tbl[9] = '{idle,                                                4'b0010};

        rst = 1'b1;
        mem_dOut = 8'h00;
        drive(idle);
        model_reset();
        #3;
        chk("reset_state", 64'({cpu_gnt, dma_gnt, mem_re, mem_we, mem_addr, mem_dIn,
                                cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].s, obs);
            chk($sformatf("table%0d", i), 64'(obs), 64'(tbl[i].exp));
        end

        // Reset in the cycle carrying read data, with both requests held through it.
        s = mk(1, 0, 21'h000400, 8'h00, 1, 0, 21'h0A0000, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            s.ca = 21'h000400 + 21'(i);
            cyc(s, obs);
        end
        drive(s);
        #1;
        chk("pre_rst_rvalid", 64'({cpu_rvalid, cpu_rdata}), 64'({1'b1, hval(21'h000404)}));
        rst = 1'b1;
        #1;
        chk("rst_async_drop", 64'({cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata}), 64'(0));
        chk("rst_gnt_cpu", 64'({cpu_gnt, dma_gnt}), 64'(2'b10));
        @(posedge clk);
        #1;
        chk("rst_read_no_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'(0));
        rst = 1'b0;
        model_reset();

        // Contention after reset: counters start from zero -> CPUx8, DMA, CPUx8, DMA, CPUx2.
        for (int i = 0; i < 20; i++) begin
            cyc(s, obs);
            chk($sformatf("contend%0d", i), 64'(obs[3:2]), 64'((i == 8 || i == 17) ? 2'b01 : 2'b10));
        end
        cyc(idle, obs);

        // Lock with no CPU demand persists; then CPU waits through 32 locked grants.
        s = mk(0, 0, 21'h000777, 8'h00, 1, 0, 21'h100000, 8'h00, 1);
        for (int i = 0; i < 40; i++) begin
            s.da = 21'h100000 + 21'(i);
            cyc(s, obs);
            if (i == 39) chk("lock_persist", 64'(obs[3:2]), 64'(2'b01));
        end
        s.cr = 1'b1;
        for (int i = 0; i < 33; i++) begin
            cyc(s, obs);
            chk($sformatf("lock_burst%0d", i), 64'(obs[3:2]), 64'((i == 32) ? 2'b10 : 2'b01));
        end
        cyc(idle, obs);

        // Random traffic; a losing requester keeps its request and operands.
        cpend = 1'b0; dpend = 1'b0; s = idle;
        for (int i = 0; i < 3000; i++) begin
            if (!cpend) begin
                s.cr = ($urandom_range(0, 3) != 0);
                s.cw = 1'($urandom);
                s.ca = 21'($urandom);
                s.cd = 8'($urandom);
            end
            if (!dpend) begin
                s.dr = ($urandom_range(0, 7) != 0);
                s.dw = 1'($urandom);
                s.da = 21'($urandom);
                s.dd = 8'($urandom);
            end
            if ($urandom_range(0, 31) == 0) s.dl = ~s.dl;
            cyc(s, obs);
            cpend = s.cr && !obs[3];
            dpend = s.dr && !obs[2];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
